fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/wait_timer.sv | 26 ++
 rtl/fetch_sequencer.sv | 113 +++++++++++
 tb/tb_fetch_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch sequencer: widths, state encodings and opcodes.
package cpu_pkg;

    localparam int PC_W    = 12;
    localparam int INSTR_W = 16;

    localparam logic [3:0] OP_JMP = 4'b1010;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[INSTR_W-1 -: 4];
    endfunction

endpackage

// File: rtl/wait_timer.sv
// Up-counter of cycles spent waiting for an ack; flags the cycle that completes LIMIT waits.
module wait_timer #(
    parameter logic [7:0] LIMIT = 8'd255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= 8'd0;
        else if (clear)
            count <= 8'd0;
        else if (enable)
            count <= count + 8'd1;
    end

    // High during the LIMIT-th consecutive wait cycle, so the request is held exactly LIMIT cycles.
    assign expired = enable && (count == LIMIT - 8'd1);

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch/decode/execute sequencer with data-RAM handshake and ack timeout.
//  state  | meaning
//  IDLE   | stopped, waiting for run
//  FETCH  | imem_req held until imem_ack
//  DECODE | one-cycle decode_en strobe
//  EXEC   | sample jump / memory flags from control unit
//  MEM    | dmem_req held until dmem_ack
//  FAULT  | ack timeout, parked until reset
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 12'h000,
    parameter int unsigned     TIMEOUT  = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    output logic [PC_W-1:0]    imem_addr,
    output logic               imem_req,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instruction,
    output logic               decode_en,
    input  logic               must_jump,
    input  logic [PC_W-1:0]    jump_addr,
    input  logic               read_ram,
    input  logic               write_ram,
    output logic               dmem_req,
    output logic               dmem_we,
    input  logic               dmem_ack,
    output logic [PC_W-1:0]    pc,
    output logic [2:0]         state,
    output logic               busy,
    output logic               fault
);

    state_t cur, nxt;
    logic [PC_W-1:0] pc_q, pc_nxt;
    logic [INSTR_W-1:0] instr_q;
    logic we_q;
    logic waiting, got_ack, expired;

    assign waiting = (cur == S_FETCH) || (cur == S_MEM);
    assign got_ack = ((cur == S_FETCH) && imem_ack) || ((cur == S_MEM) && dmem_ack);

    wait_timer #(.LIMIT(8'(TIMEOUT))) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (!waiting || got_ack),
        .enable  (waiting && !got_ack),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur     <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            we_q    <= 1'b0;
        end else begin
            cur  <= nxt;
            pc_q <= pc_nxt;
            if (cur == S_FETCH && imem_ack)
                instr_q <= imem_data;
            if (cur == S_EXEC)
                we_q <= write_ram;
        end
    end

    always_comb begin
        nxt    = cur;
        pc_nxt = pc_q;
        case (cur)
            S_IDLE:   if (run) nxt = S_FETCH;
            S_FETCH: begin
                if (imem_ack)     nxt = S_DECODE;
                else if (expired) nxt = S_FAULT;
            end
            S_DECODE: nxt = S_EXEC;
            S_EXEC: begin
                if (read_ram || write_ram) begin
                    nxt = S_MEM;
                end else begin
                    pc_nxt = must_jump ? jump_addr : pc_q + 12'd1;
                    nxt    = run ? S_FETCH : S_IDLE;
                end
            end
            S_MEM: begin
                if (dmem_ack) begin
                    pc_nxt = pc_q + 12'd1;
                    nxt    = run ? S_FETCH : S_IDLE;
                end else if (expired) begin
                    nxt = S_FAULT;
                end
            end
            S_FAULT:  nxt = S_FAULT;
            default:  nxt = S_IDLE;
        endcase
    end

    // Outputs decode straight from the state register so reset drops them without a clock.
    assign imem_addr   = pc_q;
    assign imem_req    = (cur == S_FETCH);
    assign decode_en   = (cur == S_DECODE);
    assign dmem_req    = (cur == S_MEM);
    assign dmem_we     = (cur == S_MEM) && we_q;
    assign instruction = instr_q;
    assign pc          = pc_q;
    assign state       = cur;
    assign busy        = (cur != S_IDLE) && (cur != S_FAULT);
    assign fault       = (cur == S_FAULT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: default instance plus a TIMEOUT=4 instance for the fault path.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst, run, imem_ack, must_jump, read_ram, write_ram, dmem_ack;
    logic [15:0] imem_data;
    logic [11:0] jump_addr;
    logic [11:0] imem_addr, pc;
    logic        imem_req, decode_en, dmem_req, dmem_we, busy, fault;
    logic [15:0] instruction;
    logic [2:0]  state;

    logic        rst_t, run_t, ack_t, dack_t;
    logic [11:0] imem_addr_t, pc_t;
    logic        imem_req_t, decode_en_t, dmem_req_t, dmem_we_t, busy_t, fault_t;
    logic [15:0] instruction_t;
    logic [2:0]  state_t_o;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk(clk), .rst(rst), .run(run),
        .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack), .imem_data(imem_data),
        .instruction(instruction), .decode_en(decode_en),
        .must_jump(must_jump), .jump_addr(jump_addr), .read_ram(read_ram), .write_ram(write_ram),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .pc(pc), .state(state), .busy(busy), .fault(fault)
    );

    fetch_sequencer #(.TIMEOUT(4)) dut_t (
        .clk(clk), .rst(rst_t), .run(run_t),
        .imem_addr(imem_addr_t), .imem_req(imem_req_t), .imem_ack(ack_t), .imem_data(imem_data),
        .instruction(instruction_t), .decode_en(decode_en_t),
        .must_jump(1'b0), .jump_addr(12'h000), .read_ram(1'b0), .write_ram(1'b0),
        .dmem_req(dmem_req_t), .dmem_we(dmem_we_t), .dmem_ack(dack_t),
        .pc(pc_t), .state(state_t_o), .busy(busy_t), .fault(fault_t)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic fetch(input logic [15:0] data, input logic [11:0] addr);
        int n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_wait", 32'(n < 20), 32'd1);
        chk("imem_addr", 32'(imem_addr), 32'(addr));
        imem_data = data;
        imem_ack  = 1'b1;
        @(negedge clk);
        imem_ack  = 1'b0;
        chk("decode_en_on", 32'(decode_en), 32'd1);
        chk("instruction", 32'(instruction), 32'(data));
        @(negedge clk);
        chk("decode_en_off", 32'(decode_en), 32'd0);
        chk("exec_state", 32'(state), 32'd3);
    endtask

    task automatic exec(input logic mj, input logic [11:0] ja, input logic rd, input logic wr);
        must_jump = mj; jump_addr = ja; read_ram = rd; write_ram = wr;
        @(negedge clk);
        must_jump = 1'b0; jump_addr = 12'h000; read_ram = 1'b0; write_ram = 1'b0;
    endtask

    initial begin
        int hi, n;
        logic any_req;
        rst = 1'b1; run = 1'b0; imem_ack = 1'b0; imem_data = 16'h0000; must_jump = 1'b0;
        jump_addr = 12'h000; read_ram = 1'b0; write_ram = 1'b0; dmem_ack = 1'b0;
        rst_t = 1'b1; run_t = 1'b0; ack_t = 1'b0; dack_t = 1'b0;
        @(negedge clk);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_pc", 32'(pc), 32'h000);
        chk("rst_instr", 32'(instruction), 32'h0000);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_reqs", 32'({imem_req, decode_en, dmem_req, dmem_we}), 32'd0);

        // Plain instruction, same-cycle ack
        rst = 1'b0; run = 1'b1;
        fetch(16'hD305, 12'h000);
        exec(1'b0, 12'h000, 1'b0, 1'b0);
        chk("inc_pc", 32'(pc), 32'h001);
        chk("inc_state", 32'(state), 32'd1);
        chk("inc_next_addr", 32'(imem_addr), 32'h001);

        // Jump
        fetch(16'hA123, 12'h001);
        exec(1'b1, 12'h123, 1'b0, 1'b0);
        chk("jmp_addr", 32'(imem_addr), 32'h123);

        // Write with ack on the 5th MEM cycle
        fetch(16'h4000, 12'h123);
        exec(1'b0, 12'h000, 1'b0, 1'b1);
        hi = 0;
        for (int i = 0; i < 5; i++) begin
            if (dmem_req && dmem_we) hi++;
            if (i == 4) dmem_ack = 1'b1;
            @(negedge clk);
        end
        dmem_ack = 1'b0;
        chk("wr_hi_cycles", 32'(hi), 32'd5);
        chk("wr_req_drop", 32'({dmem_req, dmem_we}), 32'd0);
        chk("wr_pc", 32'(pc), 32'h124);

        // Wrap from 0xFFF
        fetch(16'h1000, 12'h124);
        exec(1'b1, 12'hFFF, 1'b0, 1'b0);
        chk("jmp_fff", 32'(pc), 32'hFFF);
        fetch(16'h2000, 12'hFFF);
        exec(1'b0, 12'h000, 1'b0, 1'b0);
        chk("wrap_pc", 32'(pc), 32'h000);

        // Read and write both set: write wins
        fetch(16'h5000, 12'h000);
        exec(1'b0, 12'h000, 1'b1, 1'b1);
        chk("both_we", 32'({dmem_req, dmem_we}), 32'd3);
        dmem_ack = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b0;
        chk("both_pc", 32'(pc), 32'h001);

        // Read, run dropped mid-MEM
        fetch(16'h3000, 12'h001);
        exec(1'b0, 12'h000, 1'b1, 1'b0);
        chk("rd_we", 32'({dmem_req, dmem_we}), 32'd2);
        run = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rd_held", 32'(state), 32'd4);
        dmem_ack = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b0;
        chk("stop_state", 32'(state), 32'd0);
        chk("stop_busy", 32'(busy), 32'd0);
        chk("stop_pc", 32'(pc), 32'h002);

        // Stray acks in IDLE are ignored
        any_req = 1'b0;
        imem_data = 16'hBEEF;
        for (int i = 0; i < 3; i++) begin
            imem_ack = 1'b1; dmem_ack = 1'b1;
            @(negedge clk);
            any_req = any_req | imem_req | dmem_req;
        end
        imem_ack = 1'b0; dmem_ack = 1'b0;
        chk("idle_no_req", 32'(any_req), 32'd0);
        chk("idle_pc", 32'(pc), 32'h002);
        chk("idle_instr", 32'(instruction), 32'h3000);

        // Asynchronous reset in the middle of a fetch
        run = 1'b1;
        n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("pre_rst_addr", 32'(imem_addr), 32'h002);
        rst = 1'b1;
        #1;
        chk("async_req", 32'(imem_req), 32'd0);
        chk("async_state", 32'(state), 32'd0);
        chk("async_pc", 32'(pc), 32'h000);
        chk("async_instr", 32'(instruction), 32'h0000);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("refetch_addr", 32'({imem_req, imem_addr}), 32'h1000);
        run = 1'b0;

        // Fetch timeout on TIMEOUT=4 instance
        rst_t = 1'b0; run_t = 1'b1;
        hi = 0; n = 0;
        while (fault_t !== 1'b1 && n < 30) begin
            @(negedge clk);
            if (imem_req_t) hi++;
            n++;
        end
        chk("to_req_cycles", 32'(hi), 32'd4);
        chk("to_fault", 32'(fault_t), 32'd1);
        chk("to_state", 32'(state_t_o), 32'd5);
        chk("to_req_drop", 32'({imem_req_t, dmem_req_t, busy_t}), 32'd0);
        ack_t = 1'b1;
        @(negedge clk);
        @(negedge clk);
        ack_t = 1'b0;
        chk("to_stuck", 32'({fault_t, state_t_o}), 32'hD);
        chk("to_pc_hold", 32'(pc_t), 32'h000);
        rst_t = 1'b1;
        #1;
        chk("to_rst_state", 32'({fault_t, state_t_o}), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
